// File: rtl/fpu_defs.sv
// fpu_defs: shared FPU result widths, flag bit positions and buffer entry type
package fpu_defs;
    localparam int C_OP   = 32;
    localparam int C_FLAG = 9;
    localparam int C_TAG  = 5;
    localparam int FLAG_OF   = 0;
    localparam int FLAG_UF   = 1;
    localparam int FLAG_ZERO = 4;
    localparam int FLAG_IX   = 5;
    localparam int FLAG_IV   = 6;
    localparam int FLAG_INF  = 7;
    typedef struct packed {
        logic [C_OP-1:0]   result;
        logic [C_FLAG-1:0] flags;
        logic [C_TAG-1:0]  tag;
    } entry_t;
endpackage

// File: rtl/fpu_result_buffer.sv
// fpu_result_buffer: in-order FIFO between FPU results and consumer, with sticky flag accumulation
module fpu_result_buffer
    import fpu_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       Clk_CI,
    input  logic                       Rst_RI,
    input  logic                       Req_SI,
    input  logic [C_OP-1:0]            Result_DI,
    input  logic [C_FLAG-1:0]          Flags_DI,
    input  logic [C_TAG-1:0]           Tag_DI,
    output logic                       Ack_SO,
    output logic                       Valid_SO,
    output logic [C_OP-1:0]            Result_DO,
    output logic [C_FLAG-1:0]          Flags_DO,
    output logic [C_TAG-1:0]           Tag_DO,
    input  logic                       Ready_SI,
    input  logic                       ClearFlags_SI,
    output logic [C_FLAG-1:0]          FlagsAcc_DO,
    output logic [$clog2(DEPTH+1)-1:0] Count_SO,
    output logic                       Full_SO,
    output logic                       Empty_SO
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    entry_t            mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [C_FLAG-1:0] flags_acc;
    logic              push, pop;

    // Handshakes depend only on the registered count, never on Req/Ready
    assign Full_SO     = count == CW'(DEPTH);
    assign Empty_SO    = count == '0;
    assign Ack_SO      = ~Full_SO;
    assign Valid_SO    = ~Empty_SO;
    assign push        = Req_SI & Ack_SO;
    assign pop         = Valid_SO & Ready_SI;
    assign Count_SO    = count;
    assign FlagsAcc_DO = flags_acc;
    assign {Result_DO, Flags_DO, Tag_DO} = mem[rd_ptr];

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            flags_acc <= '0;
        end else begin
            wr_ptr    <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count     <= count + CW'(push) - CW'(pop);
            flags_acc <= push ? (ClearFlags_SI ? '0 : flags_acc) | Flags_DI :
                         ClearFlags_SI ? '0 : flags_acc;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (push && !Rst_RI)
            mem[wr_ptr] <= '{result: Result_DI, flags: Flags_DI, tag: Tag_DI};
    end
endmodule

// File: tb/tb_fpu_result_buffer.sv
// tb_fpu_result_buffer: directed scenarios plus randomized traffic checked by a queue-based scoreboard
module tb_fpu_result_buffer;
    import fpu_defs::*;
    localparam int DEPTH = 4;
    localparam int EW = C_OP + C_FLAG + C_TAG;

    logic              clk = 0;
    logic              Rst = 1, Req = 0, Ready = 0, Clr = 0;
    logic [C_OP-1:0]   Res = '0, ResO;
    logic [C_FLAG-1:0] Flg = '0, FlgO, Acc;
    logic [C_TAG-1:0]  Tag = '0, TagO;
    logic              Ack, Valid, Full, Empty;
    logic [2:0]        Count;
    logic              started = 0;
    int                checks = 0, errors = 0;

    logic [EW-1:0]     q[$];
    logic [C_FLAG-1:0] acc_m = '0;

    fpu_result_buffer #(.DEPTH(DEPTH)) dut (
        .Clk_CI(clk), .Rst_RI(Rst), .Req_SI(Req), .Result_DI(Res), .Flags_DI(Flg), .Tag_DI(Tag),
        .Ack_SO(Ack), .Valid_SO(Valid), .Result_DO(ResO), .Flags_DO(FlgO), .Tag_DO(TagO),
        .Ready_SI(Ready), .ClearFlags_SI(Clr), .FlagsAcc_DO(Acc), .Count_SO(Count),
        .Full_SO(Full), .Empty_SO(Empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Scoreboard: verify visible state against the model, then apply the handshakes of the coming edge
    always @(negedge clk) if (started) begin
        int  n;
        logic do_pop, do_push;
        n = q.size();
        chk("count", 64'(Count), 64'(n));
        chk("valid", 64'(Valid), 64'(n != 0));
        chk("empty", 64'(Empty), 64'(n == 0));
        chk("full", 64'(Full), 64'(n == DEPTH));
        chk("ack", 64'(Ack), 64'(n != DEPTH));
        chk("flags_acc", 64'(Acc), 64'(acc_m));
        if (Rst) begin
            q.delete();
            acc_m = '0;
        end else begin
            do_pop  = Ready && n != 0;
            do_push = Req && n != DEPTH;
            if (do_pop) begin
                chk("head", 64'({ResO, FlgO, TagO}), 64'(q[0]));
                void'(q.pop_front());
            end
            if (do_push) begin
                q.push_back({Res, Flg, Tag});
                acc_m = (Clr ? '0 : acc_m) | Flg;
            end else if (Clr) acc_m = '0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [C_OP-1:0] r, input logic [C_FLAG-1:0] f, input logic [C_TAG-1:0] t, input logic c);
        bit ok = 0;
        Req = 1; Res = r; Flg = f; Tag = t; Clr = c;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (Ack) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        step();
        Req = 0; Clr = 0;
    endtask

    task automatic drain();
        bit ok = 0;
        Ready = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (Empty) begin ok = 1; break; end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        step();
        Ready = 0;
    endtask

    initial begin
        logic done, a;
        step();
        started = 1;
        step();
        Rst = 0;

        // Reset release and single push latency
        @(negedge clk);
        chk("rst_valid", 64'(Valid), 0);
        chk("rst_ack", 64'(Ack), 1);
        chk("rst_count", 64'(Count), 0);
        chk("rst_acc", 64'(Acc), 0);
        step();
        send(32'h3F80_0000, '0, 5'd3, 0);
        @(negedge clk);
        chk("first_valid", 64'(Valid), 1);
        chk("first_result", 64'(ResO), 64'h3F80_0000);
        chk("first_tag", 64'(TagO), 3);
        step();
        drain();

        // Fill with consumer stalled, fifth request held
        for (int i = 0; i < 4; i++) send($urandom, '0, 5'(i), 0);
        Req = 1; Tag = 5'd4; Res = 32'hDEAD_0004; Flg = '0;
        @(negedge clk);
        chk("fill_ack", 64'(Ack), 0);
        chk("fill_full", 64'(Full), 1);
        chk("fill_count", 64'(Count), 4);
        step();
        Ready = 1;
        step();
        Ready = 0;
        @(negedge clk);
        chk("after_pop_count", 64'(Count), 3);
        chk("after_pop_ack", 64'(Ack), 1);
        step();
        Req = 0;
        @(negedge clk);
        chk("fifth_accepted", 64'(Count), 4);
        step();
        drain();

        // Continuous transfer at occupancy 2 across pointer wrap
        send($urandom, '0, 5'd10, 0);
        send($urandom, '0, 5'd11, 0);
        Req = 1; Ready = 1;
        for (int k = 0; k < 10; k++) begin
            Tag = 5'(12 + k); Res = $urandom;
            @(negedge clk);
            chk("stream_count", 64'(Count), 2);
            step();
        end
        Req = 0;
        drain();

        // Flag accumulation and clear-with-push
        Clr = 1;
        step();
        Clr = 0;
        send($urandom, 9'h001, 5'd1, 0);
        send($urandom, 9'h020, 5'd2, 0);
        @(negedge clk);
        chk("acc_or", 64'(Acc), 64'h021);
        step();
        send($urandom, 9'h040, 5'd3, 1);
        @(negedge clk);
        chk("acc_clear_push", 64'(Acc), 64'h040);
        step();
        drain();

        // Reset mid-operation discards entries and ignores the handshake in that cycle
        for (int i = 0; i < 3; i++) send($urandom, 9'h080, 5'(20 + i), 0);
        @(negedge clk);
        chk("pre_rst_count", 64'(Count), 3);
        step();
        Rst = 1; Req = 1; Tag = 5'd9; Ready = 1;
        step();
        Rst = 0; Req = 0; Ready = 0;
        @(negedge clk);
        chk("mid_rst_count", 64'(Count), 0);
        chk("mid_rst_valid", 64'(Valid), 0);
        chk("mid_rst_acc", 64'(Acc), 0);
        step();
        send(32'h4000_0000, '0, 5'd7, 0);
        @(negedge clk);
        chk("post_rst_tag", 64'(TagO), 7);
        chk("post_rst_count", 64'(Count), 1);
        step();
        drain();

        // Random traffic; the request holds its payload until accepted
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            done = Req && Ack;
            step();
            if (!Req || done) begin
                Req = ($urandom % 3) != 0;
                Res = $urandom; Flg = 9'($urandom); Tag = 5'($urandom);
            end
            Clr = ($urandom % 16) == 0;
            Ready = ($urandom % 3) != 0;
            if (c % 50 == 0) begin
                a = Ack;
                Ready = ~Ready;
                #1;
                chk("ack_vs_ready", 64'(Ack), 64'(a));
                Ready = ~Ready;
            end
        end
        @(negedge clk);
        step();
        Req = 0; Clr = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_result_buffer.md
FPU_RESULT_BUFFER -- requirements
Module: fpu_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries; power of two, at least 2.
REQ-002 SHALL take widths C_OP, C_FLAG (9) and C_TAG from fpu_defs, not from module parameters.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL provide these ports:
- Clk_CI  in  1  clock; all state changes on the rising edge.
- Rst_RI  in  1  synchronous active-high reset.
- Req_SI  in  1  upstream FPU result request; held until acknowledged.
- Result_DI  in  C_OP  upstream result.
- Flags_DI  in  C_FLAG  upstream flags {0,Inf,IV,IX,Zero,0,0,UF,OF}.
- Tag_DI  in  C_TAG  upstream tag.
- Ack_SO  out  1  upstream acknowledge.
- Valid_SO  out  1  head entry valid.
- Result_DO  out  C_OP  head result.
- Flags_DO  out  C_FLAG  head flags.
- Tag_DO  out  C_TAG  head tag.
- Ready_SI  in  1  downstream consumer accepts the head entry.
- ClearFlags_SI  in  1  clear the accumulated flags.
- FlagsAcc_DO  out  C_FLAG  sticky OR of all accepted flags.
- Count_SO  out  $clog2(DEPTH+1)  current occupancy.
- Full_SO  out  1  occupancy equals DEPTH.
- Empty_SO  out  1  occupancy equals 0.

Function
REQ-005 SHALL drive Ack_SO = ~Full_SO, derived only from registered state; no combinational path from Ready_SI or Req_SI.
REQ-006 SHALL push on a rising edge where Req_SI & Ack_SO, writing {Result_DI, Flags_DI, Tag_DI} at the write pointer.
REQ-007 SHALL pop on a rising edge where Valid_SO & Ready_SI, advancing the read pointer.
REQ-008 SHALL drive Valid_SO = ~Empty_SO, with Result_DO/Flags_DO/Tag_DO taken from the head entry; no fall-through.
REQ-009 SHALL give push-to-Valid_SO latency of exactly 1 cycle when empty.
REQ-010 SHALL hold head outputs stable while Valid_SO & ~Ready_SI.
REQ-011 SHALL keep Count unchanged on a simultaneous push and pop, and apply both pointer updates.
REQ-012 SHALL refuse a push when full, since Ack_SO=0, even if a pop occurs in the same cycle; the FPU holds its request.
REQ-013 SHALL ignore Ready_SI when empty, leaving pointers and Count unchanged.
REQ-014 SHALL use pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-015 SHALL derive Full/Empty from a registered Count, not from pointer comparison.
REQ-016 SHALL update FlagsAcc on an accepted push: next = (ClearFlags_SI ? 0 : FlagsAcc) | Flags_DI.
REQ-017 SHALL, when ClearFlags_SI is set without a push, clear FlagsAcc to 0 on the next edge.
REQ-018 SHALL preserve entry order exactly, with no reordering by tag.

Reset
REQ-019 SHALL, while Rst_RI=1 at an edge, set pointers=0, Count=0 and FlagsAcc=0.
REQ-020 SHALL produce these output values after reset: Valid_SO=0, Empty_SO=1, Full_SO=0, Ack_SO=1, Count_SO=0 and FlagsAcc_DO=0.
REQ-021 SHALL need no reset on the storage array; Result_DO/Flags_DO/Tag_DO are don't-care while Valid_SO=0.
REQ-022 SHALL discard all buffered entries on reset mid-operation, and ignore pushes and pops in the reset cycle.

Structure
REQ-023 SHALL place C_OP, C_FLAG, C_TAG and the flag bit-position constants (OF=0, UF=1, Zero=4, IX=5, IV=6, Inf=7) in fpu_defs.
REQ-024 SHALL be a single module with no sub-modules; storage is an in-module array of packed {result, flags, tag} entries.

Verification
REQ-025 SHALL cover reset release: Valid_SO=0, Ack_SO=1, Count_SO=0; then push Result=0x3F800000, Tag=3 -> next cycle Valid_SO=1, Result_DO=0x3F800000, Tag_DO=3.
REQ-026 SHALL cover fill with Ready_SI=0: push 5 requests, DEPTH=4 -> Ack_SO=0 after the 4th push, Full_SO=1, Count_SO=4, 5th request held; assert Ready_SI 1 cycle -> tags pop in order 0..3 and the 5th is accepted the cycle after Full_SO drops.
REQ-027 SHALL cover simultaneous push and pop at Count_SO=2 -> Count stays 2, order preserved across pointer wrap after 10 continuous transfers.
REQ-028 SHALL cover flag accumulation: push Flags=0x001 then 0x020 -> FlagsAcc_DO=0x021; ClearFlags_SI with push Flags=0x040 -> FlagsAcc_DO=0x040.
REQ-029 SHALL cover reset mid-operation: Count_SO=3, assert Rst_RI 1 cycle -> Count_SO=0, Valid_SO=0, FlagsAcc_DO=0, and no stale entry appears after the next push.
REQ-030 SHALL cover random Req_SI/Ready_SI over 10k cycles against a scoreboard queue: no loss, duplication or reorder; Ack_SO never depends on Ready_SI in the same cycle.
